// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the debug/loader port, the arbiter and the data memory.
// slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (priority) and the debug/loader port.
// Define DMEM_ARB_PERF_EN to add the perf_cpu_cnt/perf_dbg_cnt/perf_stall_cnt counters.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_cpu_cnt,
  output logic [31:0]   perf_dbg_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              win_dbg_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [DATA_W-1:0] resp_rdata;
  logic              grant, dbg_win;
  logic              cpu_done, dbg_ack;

  assign grant      = (state_q == StIdle) && (bus.cpu_req || bus.dbg_req);
  // Debug only overtakes a pending CPU request once the CPU has won StarveMax times in a row.
  assign dbg_win    = bus.dbg_req && (!bus.cpu_req || (starve_q == StarveMax));
  assign resp_rdata = we_q ? '0 : bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.cpu_req || bus.dbg_req) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (grant) begin
      if (dbg_win || !bus.dbg_req) begin
        starve_d = '0;
      end else if (starve_q != StarveMax) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q    <= '0;
      win_dbg_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (grant) begin
        win_dbg_q <= dbg_win;
        if (dbg_win) begin
          we_q    <= bus.dbg_we;
          addr_q  <= bus.dbg_addr;
          wdata_q <= bus.dbg_wdata;
          be_q    <= '1;
        end else begin
          we_q    <= bus.cpu_we;
          addr_q  <= bus.cpu_addr;
          wdata_q <= bus.cpu_wdata;
          be_q    <= bus.cpu_be;
        end
      end
      if (state_q == StResp) begin
        if (win_dbg_q) begin
          dbg_rdata_q <= resp_rdata;
        end else begin
          cpu_rdata_q <= resp_rdata;
        end
      end
    end
  end

  // Outputs are forced low while rst is asserted so an abandoned access never strobes or completes.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    cpu_done      = 1'b0;
    dbg_ack       = 1'b0;
    bus.cpu_rdata = cpu_rdata_q;
    bus.dbg_rdata = dbg_rdata_q;
    if (!rst) begin
      bus.cpu_rdata = '0;
      bus.dbg_rdata = '0;
    end else begin
      unique case (state_q)
        StIssue: begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = we_q;
          bus.mem_addr  = addr_q;
          bus.mem_wdata = wdata_q;
          bus.mem_be    = be_q;
        end
        StResp: begin
          if (win_dbg_q) begin
            dbg_ack       = 1'b1;
            bus.dbg_rdata = resp_rdata;
          end else begin
            cpu_done      = 1'b1;
            bus.cpu_rdata = resp_rdata;
          end
        end
        default: ;
      endcase
    end
    bus.cpu_done  = cpu_done;
    bus.dbg_ack   = dbg_ack;
    bus.cpu_stall = rst && bus.cpu_req && !cpu_done;
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_q, perf_dbg_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cpu_q   <= '0;
      perf_dbg_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (cpu_done)      perf_cpu_q   <= perf_cpu_q + 32'd1;
      if (dbg_ack)       perf_dbg_q   <= perf_dbg_q + 32'd1;
      if (bus.cpu_stall) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cpu_cnt   = perf_cpu_q;
  assign perf_dbg_cnt   = perf_dbg_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter, with a behavioural single-port memory
// that returns read data one cycle after mem_en.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_cnt, perf_dbg_cnt, perf_stall_cnt;
`endif

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_cpu_cnt  (perf_cpu_cnt),
    .perf_dbg_cnt  (perf_dbg_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  logic [31:0] mem [256];
  logic [31:0] mem_rdata_q = '0;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata_q <= mem[bus.mem_addr[9:2]];
      end
    end
  end
  assign bus.mem_rdata = mem_rdata_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a posedge in an idle cycle; returns just after the posedge leaving RESP.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rdata, output int lat);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_wdata = wdata; bus.cpu_be = be;
    lat = -1; rdata = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.cpu_done) begin
        lat = i; rdata = bus.cpu_rdata;
        break;
      end
    end
    if (lat < 0) check("cpu_done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic dbg_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    lat = -1; rdata = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.dbg_ack) begin
        lat = i; rdata = bus.dbg_rdata;
        break;
      end
    end
    if (lat < 0) check("dbg_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat, last, t_c, t_d;
    bit          got;
    int          seq[$];
    int          exp_seq[6] = '{0, 0, 0, 0, 1, 0};

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_cpu_done", {31'd0, bus.cpu_done}, 32'd0);
    check("rst_dbg_ack", {31'd0, bus.dbg_ack}, 32'd0);
    check("rst_cpu_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Seed memory through the debug port
    dbg_access(1'b1, 32'h200, 32'd9, rd, lat);
    check("dbg_wr_lat", 32'(lat), 32'd2);
    check("dbg_wr_rdata", rd, 32'd0);
    dbg_access(1'b1, 32'h210, 32'h11223344, rd, lat);

    // CPU-only load, cycle by cycle
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h200; bus.cpu_be = 4'hF;
    @(negedge clk);
    check("ld_t0_stall", {31'd0, bus.cpu_stall}, 32'd1);
    check("ld_t0_mem_en", {31'd0, bus.mem_en}, 32'd0);
    @(negedge clk);
    check("ld_t1_mem_en", {31'd0, bus.mem_en}, 32'd1);
    check("ld_t1_mem_addr", bus.mem_addr, 32'h200);
    check("ld_t1_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("ld_t1_stall", {31'd0, bus.cpu_stall}, 32'd1);
    @(negedge clk);
    check("ld_t2_done", {31'd0, bus.cpu_done}, 32'd1);
    check("ld_t2_rdata", bus.cpu_rdata, 32'd9);
    check("ld_t2_stall", {31'd0, bus.cpu_stall}, 32'd0);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("ld_t3_done", {31'd0, bus.cpu_done}, 32'd0);
    check("ld_t3_rdata_hold", bus.cpu_rdata, 32'd9);
    @(posedge clk); #1;

    // Byte-enabled CPU store then load back
    cpu_access(1'b1, 32'h210, 32'hAABBCCDD, 4'b0011, rd, lat);
    check("st_rdata_zero", rd, 32'd0);
    check("st_lat", 32'(lat), 32'd2);
    cpu_access(1'b0, 32'h210, 32'd0, 4'hF, rd, lat);
    check("st_be_merge", rd, 32'h1122CCDD);

    // Debug preload 0..9 with dbg_req held: acks 3 cycles apart
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1;
    last = 0;
    for (int i = 0; i < 10; i++) begin
      bus.dbg_addr = 32'h200 + 32'(4 * i);
      bus.dbg_wdata = 32'(i);
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (i == 0 && bus.mem_en) check("dbg_be_ones", {28'd0, bus.mem_be}, 32'hF);
        if (bus.dbg_ack) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) check("preload_ack_timeout", 32'd0, 32'd1);
      if (i > 0) check("preload_ack_spacing", 32'(cyc - last), 32'd3);
      last = cyc;
      @(posedge clk); #1;
    end
    bus.dbg_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dbg_access(1'b0, 32'h200 + 32'(4 * i), 32'd0, rd, lat);
      check("readback", rd, 32'(i));
    end

    // Simultaneous requests: CPU first, debug 3 cycles later
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h208; bus.cpu_be = 4'hF;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h20C;
    t_c = -100; t_d = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.cpu_done) begin
        t_c = cyc; bus.cpu_req = 1'b0;
        check("sim_cpu_rdata", bus.cpu_rdata, 32'd2);
      end
      if (bus.dbg_ack) begin
        t_d = cyc; bus.dbg_req = 1'b0;
        check("sim_dbg_rdata", bus.dbg_rdata, 32'd3);
        break;
      end
    end
    check("sim_order_gap", 32'(t_d - t_c), 32'd3);
    @(posedge clk); #1;

    // Starvation: both held, expect C C C C D C
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h208;
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h20C;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (bus.cpu_done) seq.push_back(0);
      if (bus.dbg_ack) begin
        seq.push_back(1);
        bus.dbg_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    check("starve_count", 32'(seq.size()), 32'd6);
    for (int k = 0; k < 6 && k < seq.size(); k++) check("starve_seq", 32'(seq[k]), 32'(exp_seq[k]));
    @(posedge clk); #1;

    // Reset during ISSUE of a CPU store
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h214;
    bus.cpu_wdata = 32'hDEADBEEF; bus.cpu_be = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; bus.cpu_req = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_done", {31'd0, bus.cpu_done}, 32'd0);
    check("post_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("post_rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check("post_rst_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk); #1;
    cpu_access(1'b0, 32'h208, 32'd0, 4'hF, rd, lat);
    check("fresh_lat", 32'(lat), 32'd2);
    check("fresh_rdata", rd, 32'd2);
    cpu_access(1'b0, 32'h20C, 32'd0, 4'hF, rd, lat);
    check("ld_20c", rd, 32'd3);
    cpu_access(1'b0, 32'h224, 32'd0, 4'hF, rd, lat);
    check("ld_224", rd, 32'd9);
`ifdef DMEM_ARB_PERF_EN
    check("perf_cpu", perf_cpu_cnt, 32'd3);
    check("perf_dbg", perf_dbg_cnt, 32'd0);
    check("perf_stall", perf_stall_cnt, 32'd6);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
